mul_acc: RTL and testbench
==========================

MUL_ACC -- requirements
Module: mul_acc

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter STEP, default 1, multiplier bits retired per CALC cycle; legal values 1, 2, 4, 8; SHALL divide WIDTH.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start_i  in  1  request; held high by the EX stage until ready_o is seen.
REQ-006 annul_i  in  1  cancel the current operation (flush/exception).
REQ-007 signed_i  in  1  1 = two's-complement operands, 0 = unsigned.
REQ-008 op_i  in  2  00 MUL, 01 MADD, 10 MSUB, 11 reserved (treated as MUL).
REQ-009 opdata1_i, opdata2_i  in  WIDTH each  multiplicand and multiplier.
REQ-010 hilo_i  in  2*WIDTH  forwarded {HI,LO} accumulator value.
REQ-011 result_o  out  2*WIDTH  final {HI,LO} value.
REQ-012 ready_o  out  1  result_o valid.
REQ-013 busy_o  out  1  high in CALC and ACC.

Function
REQ-014 FSM states: IDLE, CALC, ACC, DONE.
REQ-015 IDLE: start_i=1 and annul_i=0 SHALL latch op_i, signed_i, |opdata1_i|, |opdata2_i| and sign=(msb1 XOR msb2)&signed_i; clear the partial product; then go to CALC.
REQ-016 Magnitude: for signed operands with msb=1, the two's-complement negation SHALL be used; the most negative value SHALL be handled as unsigned 2^(WIDTH-1).
REQ-017 CALC SHALL last exactly WIDTH/STEP cycles; each cycle adds multiplicand*(next STEP multiplier bits) to the partial product, with the multiplier shifted LSB-first.
REQ-018 On the final CALC cycle the product SHALL be negated (mod 2^(2*WIDTH)) if sign=1, then go to ACC.
REQ-019 ACC (one cycle) SHALL sample hilo_i and form MUL: product; MADD: hilo_i+product; MSUB: hilo_i-product; all modulo 2^(2*WIDTH), with no overflow flag.
REQ-020 DONE SHALL drive ready_o=1 and hold result_o constant while start_i=1, and return to IDLE on the first cycle start_i=0.
REQ-021 Latency: ready_o SHALL first be 1 exactly WIDTH/STEP+2 cycles after the accepting clock edge (34 for 32/1).
REQ-022 Outside DONE, ready_o=0 and result_o=0.
REQ-023 Operand changes after acceptance SHALL be ignored; hilo_i is only sampled in ACC.
REQ-024 annul_i=1 in any state SHALL force IDLE on the next edge with ready_o=0; annul has priority over start_i.
REQ-025 start_i in CALC/ACC SHALL have no effect; a new start is accepted only from IDLE.
REQ-026 busy_o SHALL be 1 exactly in CALC and ACC.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, clear all datapath registers, and give ready_o=0, busy_o=0 and result_o=0 from the next cycle, including mid-operation.
REQ-028 rst SHALL take priority over annul_i and start_i.

Structure
REQ-029 The op_i encodings (MUL/MADD/MSUB) and FSM state encodings SHALL live in the shared defines package next to the existing ALU op codes.
REQ-030 The STEP-bit partial-product adder SHALL be a combinational sub-module, mul_acc_step, parametrised by WIDTH and STEP.
REQ-031 A parameter check SHALL flag illegal WIDTH/STEP combinations at elaboration.

Verification
REQ-032 W=32,S=1, unsigned MUL 0xFFFFFFFF*0xFFFFFFFF -> result 0xFFFFFFFE_00000001; ready_o rises 34 cycles after acceptance.
REQ-033 Signed MUL -3*7 -> 0xFFFFFFFF_FFFFFFEB; signed MUL 0x80000000*0x80000000 -> 0x40000000_00000000.
REQ-034 Signed MADD 2*3 with hilo_i=0x00000000_FFFFFFFF -> 0x00000001_00000005; unsigned MSUB 1*1 with hilo_i=0 -> 0xFFFFFFFF_FFFFFFFF.
REQ-035 annul_i pulse on CALC cycle 10 -> no ready_o, IDLE next cycle; an immediate new MUL 5*6 -> 30 with full latency.
REQ-036 W=32,S=4 -> latency 10 cycles, same results as REQ-032/033; rst asserted mid-CALC -> all outputs 0 from the next cycle.
REQ-037 start_i held 3 cycles in DONE -> result_o stable; start_i dropped -> ready_o=0 on the next cycle.

Source files
------------

// File: rtl/mul_acc_pkg.sv
// mul_acc_pkg: shared defines for the EX stage -- ALU op codes, multiply/accumulate op codes, multiplier FSM states.
// No ports; also provides legal_cfg(), which checks a WIDTH/STEP pair for validity.
package mul_acc_pkg;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT
    } alu_op_e;

    // The reserved encoding 2'b11 behaves as a plain multiply.
    typedef enum logic [1:0] {
        MA_MUL  = 2'b00,
        MA_MADD = 2'b01,
        MA_MSUB = 2'b10,
        MA_RSVD = 2'b11
    } ma_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ACC,
        DONE
    } ma_state_e;

    function automatic bit legal_cfg(int width, int step);
        return (width == 8 || width == 16 || width == 32 || width == 64) &&
               (step == 1 || step == 2 || step == 4 || step == 8) && (width % step == 0);
    endfunction

endpackage

// File: rtl/mul_acc_if.sv
// mul_acc_if: request/response bundle between the EX stage (master) and the multiplier (slave).
// Master drives start_i, annul_i, signed_i, op_i, opdata1_i, opdata2_i and hilo_i.
// Slave drives result_o, ready_o and busy_o.
interface mul_acc_if #(parameter int WIDTH = 32);
    logic                 start_i;
    logic                 annul_i;
    logic                 signed_i;
    logic [1:0]           op_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic [2*WIDTH-1:0]   hilo_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 busy_o;

    modport master (output start_i, annul_i, signed_i, op_i, opdata1_i, opdata2_i, hilo_i,
                    input  result_o, ready_o, busy_o);
    modport slave  (input  start_i, annul_i, signed_i, op_i, opdata1_i, opdata2_i, hilo_i,
                    output result_o, ready_o, busy_o);
endinterface

// File: rtl/mul_acc_step.sv
// mul_acc_step: combinational partial-product adder, sum = acc + mcand * mbits (mod 2^(2*WIDTH)).
// Ports: mcand -- shifted multiplicand; mbits -- next STEP multiplier bits; acc -- running partial product; sum -- updated product.
module mul_acc_step #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [STEP-1:0]    mbits,
    input  logic [2*WIDTH-1:0] acc,
    output logic [2*WIDTH-1:0] sum
);
    always_comb begin
        sum = acc;
        for (int i = 0; i < STEP; i++)
            sum = mbits[i] ? sum + (mcand << i) : sum;
    end
endmodule

// File: rtl/mul_acc.sv
// mul_acc: multi-cycle shift-add multiplier with MUL/MADD/MSUB accumulate into {HI,LO}.
// Ports: clk -- clock; rst -- synchronous active-high reset; bus -- mul_acc_if slave (request, operands, hilo in; result, ready, busy out).
module mul_acc
    import mul_acc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input logic        clk,
    input logic        rst,
    mul_acc_if.slave   bus
);
    localparam int CYC = WIDTH / STEP;
    localparam int CW  = $clog2(CYC + 1);

    if (!legal_cfg(WIDTH, STEP)) begin : g_bad_cfg
        $error("mul_acc: illegal WIDTH=%0d STEP=%0d", WIDTH, STEP);
    end

    ma_state_e          state, state_n;
    ma_op_e             op;
    logic               sign;
    logic               last;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mag1, mag2, mplier;
    logic [2*WIDTH-1:0] mcand, prod, sum, result;

    // Negating the most negative value wraps back to 2^(WIDTH-1), which is the correct unsigned magnitude.
    assign mag1 = bus.signed_i && bus.opdata1_i[WIDTH-1] ? -bus.opdata1_i : bus.opdata1_i;
    assign mag2 = bus.signed_i && bus.opdata2_i[WIDTH-1] ? -bus.opdata2_i : bus.opdata2_i;
    assign last = cnt == CW'(CYC - 1);

    mul_acc_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
        .mcand (mcand),
        .mbits (mplier[STEP-1:0]),
        .acc   (prod),
        .sum   (sum)
    );

    always_comb begin
        state_n = state;
        if (bus.annul_i)
            state_n = IDLE;
        else
            case (state)
                IDLE: state_n = bus.start_i ? CALC : IDLE;
                CALC: state_n = last ? ACC : CALC;
                ACC:  state_n = DONE;
                DONE: state_n = bus.start_i ? DONE : IDLE;
            endcase
    end

    assign bus.ready_o  = state == DONE;
    assign bus.busy_o   = state == CALC || state == ACC;
    assign bus.result_o = state == DONE ? result : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op     <= MA_MUL;
            sign   <= 1'b0;
            cnt    <= '0;
            mplier <= '0;
            mcand  <= '0;
            prod   <= '0;
            result <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && bus.start_i && !bus.annul_i) begin
                op     <= ma_op_e'(bus.op_i);
                sign   <= (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]) & bus.signed_i;
                mcand  <= {{WIDTH{1'b0}}, mag1};
                mplier <= mag2;
                prod   <= '0;
                cnt    <= '0;
            end
            // The multiplicand moves left as the multiplier is consumed LSB-first, keeping bit weights aligned.
            if (state == CALC) begin
                prod   <= last && sign ? -sum : sum;
                mcand  <= mcand << STEP;
                mplier <= mplier >> STEP;
                cnt    <= cnt + 1'b1;
            end
            if (state == ACC)
                result <= op == MA_MADD ? bus.hilo_i + prod :
                          op == MA_MSUB ? bus.hilo_i - prod : prod;
        end
    end
endmodule

// File: tb/tb_mul_acc.sv
// tb_mul_acc: self-checking bench for mul_acc at WIDTH=32 with STEP=1 (dut 0) and STEP=4 (dut 1).
// No ports; prints one summary line at the end.
module tb_mul_acc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;

    logic        rst_v [2];
    logic        start [2];
    logic        annul [2];
    logic        sgn   [2];
    logic [1:0]  op    [2];
    logic [31:0] a     [2];
    logic [31:0] b     [2];
    logic [63:0] hilo  [2];
    logic        rdy   [2];
    logic        bsy   [2];
    logic [63:0] res   [2];

    mul_acc_if #(.WIDTH(32)) b0 ();
    mul_acc_if #(.WIDTH(32)) b1 ();

    assign b0.start_i = start[0];
    assign b0.annul_i = annul[0];
    assign b0.signed_i = sgn[0];
    assign b0.op_i = op[0];
    assign b0.opdata1_i = a[0];
    assign b0.opdata2_i = b[0];
    assign b0.hilo_i = hilo[0];
    assign rdy[0] = b0.ready_o;
    assign bsy[0] = b0.busy_o;
    assign res[0] = b0.result_o;

    assign b1.start_i = start[1];
    assign b1.annul_i = annul[1];
    assign b1.signed_i = sgn[1];
    assign b1.op_i = op[1];
    assign b1.opdata1_i = a[1];
    assign b1.opdata2_i = b[1];
    assign b1.hilo_i = hilo[1];
    assign rdy[1] = b1.ready_o;
    assign bsy[1] = b1.busy_o;
    assign res[1] = b1.result_o;

    mul_acc #(.WIDTH(32), .STEP(1)) u0 (.clk(clk), .rst(rst_v[0]), .bus(b0));
    mul_acc #(.WIDTH(32), .STEP(4)) u1 (.clk(clk), .rst(rst_v[1]), .bus(b1));

    function automatic int cyc_of(int d);
        return d != 0 ? 8 : 32;
    endfunction

    // Reference: exact 64-bit product of the operands as integers, then accumulate modulo 2^64.
    function automatic logic [63:0] model(logic [1:0] o, logic s, logic [31:0] x, logic [31:0] y, logic [63:0] h);
        logic [63:0] p;
        p = s ? {{32{x[31]}}, x} * {{32{y[31]}}, y} : {32'b0, x} * {32'b0, y};
        return o == 2'b01 ? h + p : o == 2'b10 ? h - p : p;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(int d, string tag);
        check({tag, "_ready"}, 64'(rdy[d]), 64'd0);
        check({tag, "_busy"}, 64'(bsy[d]), 64'd0);
        check({tag, "_result"}, res[d], 64'd0);
    endtask

    // Issues one request the way the EX stage does (start held until ready), scrambling operands
    // after acceptance and presenting the real hilo only during the ACC cycle.
    task automatic run_op(int d, logic [1:0] o, logic s, logic [31:0] x, logic [31:0] y,
                          logic [63:0] h, logic [63:0] exp, int hold, string tag);
        int cyc;
        @(negedge clk);
        op[d] = o; sgn[d] = s; a[d] = x; b[d] = y; hilo[d] = {$urandom, $urandom}; start[d] = 1'b1;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        check({tag, "_busy"}, 64'(bsy[d]), 64'd1);
        a[d] = $urandom; b[d] = $urandom; sgn[d] = ~s; op[d] = 2'($urandom);
        while (!rdy[d] && cyc < 200) begin
            if (cyc == cyc_of(d) + 1) hilo[d] = h;
            @(negedge clk);
            cyc++;
        end
        hilo[d] = {$urandom, $urandom};
        check({tag, "_latency"}, 64'(cyc), 64'(cyc_of(d) + 2));
        check({tag, "_result"}, res[d], exp);
        check({tag, "_busy_done"}, 64'(bsy[d]), 64'd0);
        repeat (hold) begin
            @(negedge clk);
            check({tag, "_hold_ready"}, 64'(rdy[d]), 64'd1);
            check({tag, "_hold_result"}, res[d], exp);
        end
        start[d] = 1'b0;
        @(negedge clk);
        check_idle(d, {tag, "_release"});
    endtask

    initial begin
        logic [1:0]  o;
        logic        s;
        logic [31:0] x, y;
        logic [63:0] h;
        for (int d = 0; d < 2; d++) begin
            rst_v[d] = 1'b1; start[d] = 1'b0; annul[d] = 1'b0; sgn[d] = 1'b0;
            op[d] = 2'b00; a[d] = '0; b[d] = '0; hilo[d] = '0;
        end
        repeat (2) @(negedge clk);
        check_idle(0, "reset0");
        check_idle(1, "reset1");
        rst_v[0] = 1'b0; rst_v[1] = 1'b0;

        for (int d = 0; d < 2; d++) begin
            run_op(d, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 64'hFFFFFFFE_00000001, 0, "umul_max");
            run_op(d, 2'b00, 1'b1, 32'hFFFF_FFFD, 32'd7, 64'h0, 64'hFFFFFFFF_FFFFFFEB, 0, "smul_neg");
            run_op(d, 2'b00, 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h0, 64'h40000000_00000000, 0, "smul_minmin");
        end
        run_op(0, 2'b01, 1'b1, 32'd2, 32'd3, 64'h00000000_FFFFFFFF, 64'h00000001_00000005, 3, "smadd");
        run_op(0, 2'b10, 1'b0, 32'd1, 32'd1, 64'h0, 64'hFFFFFFFF_FFFFFFFF, 0, "umsub");
        run_op(1, 2'b11, 1'b0, 32'd4, 32'd5, 64'h1234, 64'd20, 1, "rsvd_mul");

        // Annul in the 10th CALC cycle while start is still high: annul must win.
        @(negedge clk);
        op[0] = 2'b00; sgn[0] = 1'b0; a[0] = 32'd9; b[0] = 32'd9; start[0] = 1'b1;
        @(posedge clk);
        repeat (10) @(negedge clk);
        check("annul_busy_calc", 64'(bsy[0]), 64'd1);
        annul[0] = 1'b1;
        @(negedge clk);
        check_idle(0, "annul");
        annul[0] = 1'b0; start[0] = 1'b0;
        run_op(0, 2'b00, 1'b0, 32'd5, 32'd6, 64'h0, 64'd30, 0, "after_annul");

        // Reset in the middle of CALC on the STEP=4 instance.
        @(negedge clk);
        op[1] = 2'b01; sgn[1] = 1'b1; a[1] = 32'd77; b[1] = 32'd88; start[1] = 1'b1;
        @(posedge clk);
        repeat (3) @(negedge clk);
        check("rst_busy_calc", 64'(bsy[1]), 64'd1);
        rst_v[1] = 1'b1;
        @(negedge clk);
        check_idle(1, "midrst");
        rst_v[1] = 1'b0; start[1] = 1'b0;
        run_op(1, 2'b00, 1'b0, 32'd5, 32'd6, 64'h0, 64'd30, 0, "after_rst");

        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom); s = 1'($urandom);
            x = $urandom; y = $urandom; h = {$urandom, $urandom};
            if (i % 6 == 0) x = 32'h8000_0000;
            if (i % 7 == 0) y = 32'hFFFF_FFFF;
            run_op(i % 2, o, s, x, y, h, model(o, s, x, y, h), i % 3, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
